// File: rtl/paralelo_serial_fifo_pkg.sv
// Shared constants for the parallel-to-serial converter.
//   IDLE_SYM_DEFAULT : filler word sent when no data is queued at a word boundary
//   MSB_FIRST_MODE / LSB_FIRST_MODE : bit-order selectors for the MSB_FIRST parameter
package paralelo_serial_pkg;

  localparam logic [7:0] IDLE_SYM_DEFAULT = 8'hBC;

  localparam bit MSB_FIRST_MODE = 1'b1;
  localparam bit LSB_FIRST_MODE = 1'b0;

endpackage

// File: rtl/paralelo_serial_fifo_if.sv
// Handshake and serial-output bundle of paralelo_serial_fifo.
//   data_in, valid_in : parallel word offered by the source
//   ready_out         : converter can accept a word this cycle
//   data_out          : serial bit
//   word_start        : data_out carries the first bit of a word
//   data_active       : data_out belongs to a real (non-idle) word
//   fifo_count        : words currently queued
// master = source side, slave = converter side.
interface paralelo_serial_fifo_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DEPTH  = 4
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;
  logic              data_out;
  logic              word_start;
  logic              data_active;
  logic [CNT_W-1:0]  fifo_count;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out,
    input  data_out,
    input  word_start,
    input  data_active,
    input  fifo_count
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out,
    output data_out,
    output word_start,
    output data_active,
    output fifo_count
  );

endinterface

// File: rtl/paralelo_serial_fifo_sync_fifo.sv
// Single-clock word FIFO with synchronous active-high reset.
//   i_clk, i_reset : clock and synchronous reset (flushes pointers and count)
//   i_push, i_data : write request and word; ignored while full
//   i_pop          : read request; ignored while empty
//   o_data         : head word (valid while !o_empty)
//   o_full, o_empty, o_count : occupancy status
module sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_push;
  logic w_pop;

  assign o_full  = (r_count == CNT_W'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  assign w_push = i_push && !o_full;
  assign w_pop  = i_pop && !o_empty;

  // Storage carries no reset; only pointers and count define the contents.
  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/paralelo_serial_fifo.sv
// Parallel-to-serial converter: buffers DATA_W-bit words in a DEPTH-word FIFO and
// shifts them out one bit per clk_32f cycle. A word boundary occurs every DATA_W
// cycles; if nothing is queued there, IDLE_SYM is sent instead.
//   clk_32f : bit clock
//   reset   : synchronous active-high reset (truncates current word, flushes FIFO)
//   bus     : slave side of paralelo_serial_fifo_if (handshake in, serial out)
module paralelo_serial_fifo
  import paralelo_serial_pkg::*;
#(
  parameter int unsigned       DATA_W    = 8,
  parameter int unsigned       DEPTH     = 4,
  parameter bit                MSB_FIRST = MSB_FIRST_MODE,
  parameter logic [DATA_W-1:0] IDLE_SYM  = DATA_W'(IDLE_SYM_DEFAULT)
) (
  input logic                   clk_32f,
  input logic                   reset,
  paralelo_serial_fifo_if.slave bus
);

  localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
  localparam int unsigned BCNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [BCNT_W-1:0] BIT_LAST = BCNT_W'(DATA_W - 1);

  logic [BCNT_W-1:0] r_bit_cnt;
  logic [DATA_W-2:0] r_shift;
  logic              r_data_out;
  logic              r_word_start;
  logic              r_data_active;

  logic              w_load;
  logic [DATA_W-1:0] w_fifo_data;
  logic              w_full;
  logic              w_empty;
  logic [CNT_W-1:0]  w_count;
  logic [DATA_W-1:0] w_word;
  logic              w_first_bit;
  logic [DATA_W-2:0] w_rest;
  logic              w_shift_bit;
  logic [DATA_W-2:0] w_shift_nxt;

  assign w_load = (r_bit_cnt == '0);

  // The pop request is the load strobe; the FIFO ignores it when empty, which
  // is exactly the case where the idle symbol is sent instead.
  sync_fifo #(
    .WIDTH (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (clk_32f),
    .i_reset (reset),
    .i_push  (bus.valid_in),
    .i_data  (bus.data_in),
    .i_pop   (w_load),
    .o_data  (w_fifo_data),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_count)
  );

  always_comb begin
    w_word = w_empty ? IDLE_SYM : w_fifo_data;
    if (MSB_FIRST) begin
      w_first_bit = w_word[DATA_W-1];
      w_rest      = w_word[DATA_W-2:0];
      w_shift_bit = r_shift[DATA_W-2];
      w_shift_nxt = r_shift << 1;
    end else begin
      w_first_bit = w_word[0];
      w_rest      = w_word[DATA_W-1:1];
      w_shift_bit = r_shift[0];
      w_shift_nxt = r_shift >> 1;
    end
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      r_bit_cnt     <= '0;
      r_shift       <= '0;
      r_data_out    <= 1'b0;
      r_word_start  <= 1'b0;
      r_data_active <= 1'b0;
    end else begin
      r_bit_cnt <= (r_bit_cnt == BIT_LAST) ? '0 : r_bit_cnt + 1'b1;
      if (w_load) begin
        r_data_out    <= w_first_bit;
        r_shift       <= w_rest;
        r_word_start  <= 1'b1;
        r_data_active <= !w_empty;
      end else begin
        r_data_out   <= w_shift_bit;
        r_shift      <= w_shift_nxt;
        r_word_start <= 1'b0;
      end
    end
  end

  assign bus.ready_out   = !w_full;
  assign bus.fifo_count  = w_count;
  assign bus.data_out    = r_data_out;
  assign bus.word_start  = r_word_start;
  assign bus.data_active = r_data_active;

endmodule

// File: tb/tb_paralelo_serial_fifo.sv
// Self-checking bench for paralelo_serial_fifo. Three instances run side by side:
//   0: DATA_W=8,  MSB first   1: DATA_W=8, LSB first   2: DATA_W=16, MSB first
// A queue-based model predicts every output each cycle; directed scenarios add
// hand-computed literal expectations.
module tb_paralelo_serial_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             reset;
  logic [15:0]      din [3];
  logic [2:0]       vin;
  logic [2:0]       dout, ws, da, rdy;
  logic [2:0][2:0]  cnt;

  paralelo_serial_fifo_if #(.DATA_W(8),  .DEPTH(4)) bus0 ();
  paralelo_serial_fifo_if #(.DATA_W(8),  .DEPTH(4)) bus1 ();
  paralelo_serial_fifo_if #(.DATA_W(16), .DEPTH(4)) bus2 ();

  assign bus0.data_in  = din[0][7:0];
  assign bus0.valid_in = vin[0];
  assign bus1.data_in  = din[1][7:0];
  assign bus1.valid_in = vin[1];
  assign bus2.data_in  = din[2];
  assign bus2.valid_in = vin[2];

  assign dout = {bus2.data_out, bus1.data_out, bus0.data_out};
  assign ws   = {bus2.word_start, bus1.word_start, bus0.word_start};
  assign da   = {bus2.data_active, bus1.data_active, bus0.data_active};
  assign rdy  = {bus2.ready_out, bus1.ready_out, bus0.ready_out};
  assign cnt[0] = bus0.fifo_count;
  assign cnt[1] = bus1.fifo_count;
  assign cnt[2] = bus2.fifo_count;

  paralelo_serial_fifo #(.DATA_W(8), .DEPTH(4), .MSB_FIRST(1'b1)) u_dut0 (
    .clk_32f (clk),
    .reset   (reset),
    .bus     (bus0)
  );
  paralelo_serial_fifo #(.DATA_W(8), .DEPTH(4), .MSB_FIRST(1'b0)) u_dut1 (
    .clk_32f (clk),
    .reset   (reset),
    .bus     (bus1)
  );
  paralelo_serial_fifo #(.DATA_W(16), .DEPTH(4), .MSB_FIRST(1'b1)) u_dut2 (
    .clk_32f (clk),
    .reset   (reset),
    .bus     (bus2)
  );

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int dw_of(input int i);
    return (i == 2) ? 16 : 8;
  endfunction

  function automatic bit msb_of(input int i);
    return (i != 1);
  endfunction

  // ---------------- behavioural model ----------------
  // Words are queued; every DATA_W cycles since reset release a new word starts,
  // taken from the queue head or the idle symbol. A push sampled on a boundary
  // edge lands behind that edge's load.
  logic [15:0] mq [3][$];
  int unsigned mcyc [3];
  logic [15:0] mword [3];
  bit          mact [3];
  logic [2:0]  e_out, e_ws, e_da;
  int          e_cnt [3];
  int          m_pos;
  bit          m_can_push;

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) begin
        mq[i].delete();
        mcyc[i] = 0;
        e_out[i] = 1'b0;
        e_ws[i]  = 1'b0;
        e_da[i]  = 1'b0;
      end else begin
        m_pos      = int'(mcyc[i] % dw_of(i));
        m_can_push = (mq[i].size() < 4);
        if (m_pos == 0) begin
          if (mq[i].size() > 0) begin
            mword[i] = mq[i].pop_front();
            mact[i]  = 1'b1;
          end else begin
            mword[i] = 16'h00BC;
            mact[i]  = 1'b0;
          end
        end
        if (vin[i] && m_can_push) begin
          mq[i].push_back((dw_of(i) == 16) ? din[i] : {8'h00, din[i][7:0]});
        end
        e_out[i] = msb_of(i) ? mword[i][dw_of(i) - 1 - m_pos] : mword[i][m_pos];
        e_ws[i]  = (m_pos == 0);
        e_da[i]  = mact[i];
        mcyc[i]++;
      end
      e_cnt[i] = mq[i].size();
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("dut%0d.data_out", i),    32'(dout[i]), 32'(e_out[i]));
        check($sformatf("dut%0d.word_start", i),  32'(ws[i]),   32'(e_ws[i]));
        check($sformatf("dut%0d.data_active", i), 32'(da[i]),   32'(e_da[i]));
        check($sformatf("dut%0d.fifo_count", i),  32'(cnt[i]),  32'(e_cnt[i]));
        check($sformatf("dut%0d.ready_out", i),   32'(rdy[i]),  32'(e_cnt[i] < 4));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input int i, input logic [15:0] d, output int waits);
    din[i] = d;
    vin[i] = 1'b1;
    waits  = 0;
    while (rdy[i] !== 1'b1 && waits < 64) begin
      @(negedge clk);
      waits++;
    end
    check($sformatf("dut%0d.ready_wait", i), 32'(rdy[i]), 32'd1);
    @(negedge clk);
    vin[i] = 1'b0;
  endtask

  task automatic wait_ws(input int i);
    int t = 0;
    while (ws[i] !== 1'b1 && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (ws[i] !== 1'b1) check($sformatf("dut%0d.word_start_wait", i), 32'(ws[i]), 32'd1);
  endtask

  // Returns the bits in transmission order, first bit in the MSB of the word field.
  task automatic capture_word(input int i, output logic [15:0] seq, output logic act);
    seq = '0;
    wait_ws(i);
    act = da[i];
    for (int b = 0; b < dw_of(i); b++) begin
      seq = {seq[14:0], dout[i]};
      if (b < dw_of(i) - 1) @(negedge clk);
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [23:0] bits24, ws24, da24;
    logic [15:0] w;
    logic        a;
    int          wt;
    logic [15:0] exp_w [7];
    logic        exp_a [7];

    reset = 1'b1;
    vin   = '0;
    for (int i = 0; i < 3; i++) din[i] = '0;
    @(negedge clk);
    chk_en = 1'b1;
    check("reset.data_out",    32'(dout[0]), 32'd0);
    check("reset.word_start",  32'(ws[0]),   32'd0);
    check("reset.data_active", 32'(da[0]),   32'd0);
    check("reset.fifo_count",  32'(cnt[0]),  32'd0);
    check("reset.ready_out",   32'(rdy[0]),  32'd1);
    @(negedge clk);
    reset = 1'b0;

    // Idle line: three BC words, word_start every 8 cycles, never active.
    for (int k = 0; k < 24; k++) begin
      @(negedge clk);
      bits24 = {bits24[22:0], dout[0]};
      ws24   = {ws24[22:0], ws[0]};
      da24   = {da24[22:0], da[0]};
    end
    check("idle.bits",        32'(bits24), 32'h00BCBCBC);
    check("idle.word_start",  32'(ws24),   32'h00808080);
    check("idle.data_active", 32'(da24),   32'h0);

    // Fill to full; the fifth word waits for the next load to free a slot.
    exp_w = '{16'hBC, 16'hFF, 16'hFF, 16'hEE, 16'hEE, 16'hEE, 16'hBC};
    exp_a = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    fork
      begin
        @(negedge clk);
        push(0, 16'hFF, wt);
        push(0, 16'hFF, wt);
        push(0, 16'hEE, wt);
        push(0, 16'hEE, wt);
        check("full.ready_out",  32'(rdy[0]), 32'd0);
        check("full.fifo_count", 32'(cnt[0]), 32'd4);
        push(0, 16'hEE, wt);
        check("full.fifth_wait_cycles", 32'(wt), 32'd4);
      end
      begin
        for (int k = 0; k < 7; k++) begin
          capture_word(0, w, a);
          check($sformatf("burst.word%0d", k),   32'(w), 32'(exp_w[k]));
          check($sformatf("burst.active%0d", k), 32'(a), 32'(exp_a[k]));
        end
      end
    join

    // LSB-first instance: idle 00111101, data 01 -> 10000000.
    fork
      push(1, 16'h0001, wt);
      begin
        capture_word(1, w, a);
        check("lsb.idle_bits",   32'(w), 32'h3D);
        check("lsb.idle_active", 32'(a), 32'd0);
        capture_word(1, w, a);
        check("lsb.data_bits",   32'(w), 32'h80);
        check("lsb.data_active", 32'(a), 32'd1);
        capture_word(1, w, a);
        check("lsb.idle2_bits",  32'(w), 32'h3D);
      end
    join

    // Reset on bit 3 of a data word with two words still queued.
    push(0, 16'hA5, wt);
    push(0, 16'h5A, wt);
    push(0, 16'h3C, wt);
    wait_ws(0);
    check("midreset.active_before", 32'(da[0]), 32'd1);
    tick(3);
    check("midreset.count_before", 32'(cnt[0]), 32'd2);
    reset = 1'b1;
    @(negedge clk);
    check("midreset.data_out",   32'(dout[0]), 32'd0);
    check("midreset.fifo_count", 32'(cnt[0]),  32'd0);
    check("midreset.ready_out",  32'(rdy[0]),  32'd1);
    check("midreset.word_start", 32'(ws[0]),   32'd0);
    reset = 1'b0;
    for (int k = 0; k < 3; k++) begin
      capture_word(0, w, a);
      check($sformatf("postreset.word%0d", k),   32'(w), 32'hBC);
      check($sformatf("postreset.active%0d", k), 32'(a), 32'd0);
    end

    // Push on the load edge with an empty FIFO: idle first, data next boundary.
    tick(7);
    push(0, 16'h77, wt);
    check("pushload.word_start", 32'(ws[0]),  32'd1);
    check("pushload.active",     32'(da[0]),  32'd0);
    check("pushload.count1",     32'(cnt[0]), 32'd1);
    capture_word(0, w, a);
    check("pushload.idle_word", 32'(w), 32'hBC);
    check("pushload.count0",    32'(cnt[0]), 32'd0);
    capture_word(0, w, a);
    check("pushload.data_word",   32'(w), 32'h77);
    check("pushload.data_active", 32'(a), 32'd1);

    // 16-bit instance.
    push(2, 16'h1234, wt);
    capture_word(2, w, a);
    check("w16.data_word",   32'(w), 32'h1234);
    check("w16.data_active", 32'(a), 32'd1);
    capture_word(2, w, a);
    check("w16.idle_word",   32'(w), 32'h00BC);
    check("w16.idle_active", 32'(a), 32'd0);

    tick(4);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
